// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the iterative RV32M multiply/divide unit
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [XLEN_DEFAULT-1:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [XLEN_DEFAULT-1:0] ALL_ONES     = 32'hFFFF_FFFF;

    function automatic logic [XLEN_DEFAULT-1:0] cond_neg(input logic [XLEN_DEFAULT-1:0] v,
                                                         input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one radix-2 iteration: shift-add multiply or restoring-divide step
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] hi;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
    // Divide:   acc = {partial remainder, dividend/quotient bits}, shifts left.
    always_comb begin
        sum     = '0;
        hi      = '0;
        acc_nxt = acc;
        if (is_div) begin
            hi = acc[2*XLEN-1:XLEN-1];
            if (hi >= {1'b0, opnd}) begin
                acc_nxt = {hi[XLEN-1:0] - opnd, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects single-cycle multiplies
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        fn;
    logic              neg_q, neg_r;

    logic              is_div_in, sgn_a, sgn_b, sa, sb;
    logic              div_zero, div_ovf, special, fast_mul, accept, last;
    logic [XLEN-1:0]   abs_a, abs_b, special_res, fast_res, fin_res;
    logic [2*XLEN-1:0] step_out, mul_p;

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (fn[2]),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (step_out)
    );

    always_comb begin
        is_div_in   = funct3[2];
        sgn_a       = (funct3 == F_MULH) || (funct3 == F_MULHSU) || (funct3 == F_DIV) || (funct3 == F_REM);
        sgn_b       = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        sa          = sgn_a & op_a[XLEN-1];
        sb          = sgn_b & op_b[XLEN-1];
        abs_a       = cond_neg(op_a, sa);
        abs_b       = cond_neg(op_b, sb);
        div_zero    = is_div_in && (op_b == '0);
        div_ovf     = is_div_in && !funct3[0] && (op_a == OVF_DIVIDEND) && (op_b == ALL_ONES);
        special     = div_zero | div_ovf;
        special_res = div_zero ? (funct3[1] ? op_a : ALL_ONES) : (funct3[1] ? '0 : OVF_DIVIDEND);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    // Sign-extending by sa/sb makes this the 33x33 signed product of the chosen operand types.
    always_comb begin
        ext_a     = {{XLEN{sa}}, op_a};
        ext_b     = {{XLEN{sb}}, op_b};
        fast_prod = ext_a * ext_b;
        fast_mul  = !is_div_in;
        fast_res  = (funct3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = '0;
    end
`endif

    // Sign correction on the final iteration's output so the result lands with done.
    always_comb begin
        mul_p = neg_q ? (~step_out + 1'b1) : step_out;
        if (fn[2]) begin
            fin_res = fn[1] ? cond_neg(step_out[2*XLEN-1:XLEN], neg_r)
                            : cond_neg(step_out[XLEN-1:0], neg_q);
        end else begin
            fin_res = (fn == F_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
        end
    end

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (state == CALC) && (cnt == CNT_W'(XLEN-1)) && !flush;
    assign busy   = (state == CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (special || fast_mul) ? FIN : CALC;
            CALC:    if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            fn     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                fn    <= funct3;
                neg_q <= sa ^ sb;
                neg_r <= sa;
                cnt   <= '0;
                acc   <= {{XLEN{1'b0}}, (is_div_in ? abs_a : abs_b)};
                opnd  <= is_div_in ? abs_b : abs_a;
                if (special) begin
                    result <= special_res;
                    done   <= 1'b1;
                end else if (fast_mul) begin
                    result <= fast_res;
                    done   <= 1'b1;
                end
            end else if ((state == CALC) && !flush) begin
                acc <= step_out;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result <= fin_res;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (vector table, random ops, flush/reset sequences)
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = (ua * ub) >> 32;
            3'd4: p = (b == 0) ? -64'sd1 : (ovf ? sa : sa / sb);
            3'd5: p = (b == 0) ? -64'sd1 : ua / ub;
            3'd6: p = (b == 0) ? sa : (ovf ? 64'sd0 : sa % sb);
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // busy must be high on every non-done cycle and low on the done cycle.
    task automatic wait_done(input int lat0, output int lat, output logic busy_ok);
        lat     = lat0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic bok;
        launch(f, a, b);
        wait_done(1, lat, bok);
        chk({name, " result"}, result, exp);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " busy"}, {31'b0, bok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] corners[6];
        logic [31:0] prev, a, b;
        logic [2:0]  f;
        int          lat;
        logic        bok;

        vecs.push_back('{F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
        vecs.push_back('{F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
        vecs.push_back('{F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         MUL_LAT});
        vecs.push_back('{F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT});
        vecs.push_back('{F_MUL,    32'h8000_0000,  32'h8000_0000, 32'h0,         MUL_LAT});
        vecs.push_back('{F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT});
        vecs.push_back('{F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{F_DIVU,   32'd100,        32'd7,         32'd14,        33});
        vecs.push_back('{F_REMU,   32'd100,        32'd7,         32'd2,         33});
        vecs.push_back('{F_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         33});
        vecs.push_back('{F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{F_REM,    32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1});

        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            run_check($sformatf("rnd%0d f%0d %08h %08h", i, f, a, b), f, a, b, ref_res(f, a, b), ref_lat(f, a, b));
        end

        // Flush mid-divide at T+10: back in IDLE at T+11, no done, result kept.
        prev = result;
        launch(F_DIV, 32'd1000, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush done", {31'b0, done}, 32'd0);
        chk("flush result", result, prev);
        run_check("after flush", F_DIV, 32'hFFFF_FC18, 32'd7, ref_res(F_DIV, 32'hFFFF_FC18, 32'd7), 33);

        // Flush and start together in IDLE: a divide-by-zero would otherwise finish next cycle.
        funct3 = F_DIVU;
        op_a   = 32'd9;
        op_b   = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush+start done", {31'b0, done}, 32'd0);
        chk("flush+start busy", {31'b0, busy}, 32'd0);

        // Start pulsed at T+4 while busy, operands disturbed afterwards.
        launch(F_DIVU, 32'd1000, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        funct3 = F_REMU;
        op_a   = 32'd5;
        op_b   = 32'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom();
        op_b  = $urandom();
        wait_done(5, lat, bok);
        chk("busy-start result", result, 32'd142);
        chk("busy-start latency", 32'(lat), 32'd33);
        chk("busy-start busy", {31'b0, bok}, 32'd1);

        // Start during the done cycle is ignored; the following cycle is accepted.
        funct3 = F_DIVU;
        op_a   = 32'd9;
        op_b   = 32'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fin-start done", {31'b0, done}, 32'd0);
        chk("fin-start busy", {31'b0, busy}, 32'd0);
        chk("fin-start result", result, 32'd142);
        run_check("back-to-back mul", F_MUL, 32'd12345, 32'hFFFF_FD5A, ref_res(F_MUL, 32'd12345, 32'hFFFF_FD5A), MUL_LAT);
        launch(F_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        wait_done(1, lat, bok);
        chk("b2b first", result, ref_res(F_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
        @(posedge clk);
        #1;
        run_check("b2b second", F_REM, 32'hFFFF_FF00, 32'd13, ref_res(F_REM, 32'hFFFF_FF00, 32'd13), 33);

        // Asynchronous reset at T+5 of a long operation.
        launch(F_DIVU, 32'd77777, 32'd3);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("async reset busy", {31'b0, busy}, 32'd0);
        chk("async reset done", {31'b0, done}, 32'd0);
        chk("async reset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset done", {31'b0, done}, 32'd0);
        run_check("post reset", F_REMU, 32'd77777, 32'd3, 32'd2, 33);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
